// File: rtl/screen_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment driver between NREQ requesters,
// with minimum dwell before preemption and a blank cycle on every owner change.
// Optional digit blinking is enabled with the SCREEN_ARB_BLINK_EN macro.
module screen_arbiter #(
  parameter int NREQ       = 4,
  parameter int DWELL      = 50_000_000
`ifdef SCREEN_ARB_BLINK_EN
  ,
  parameter int BLINK_HALF = 25_000_000
`endif
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0][7:0][3:0]   src_display,
  input  logic [NREQ-1:0][7:0]        src_dots,
  input  logic [NREQ-1:0][7:0]        src_en,
`ifdef SCREEN_ARB_BLINK_EN
  input  logic [NREQ-1:0][7:0]        src_blink,
`endif
  output logic [NREQ-1:0]             grant,
  output logic [$clog2(NREQ)-1:0]     owner,
  output logic                        busy,
  output logic [7:0][3:0]             display,
  output logic [7:0]                  dots,
  output logic [7:0]                  en
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, OWN, SWITCH} state_t;

  state_t        state, state_next;
  logic [CW-1:0] dwell;
  logic [OW-1:0] win_idx;
  logic [OW-1:0] cand;
  logic          dwell_done;
  logic          others_req;

  // Scan downwards so the smallest offset from the last owner wins; the owner itself
  // (offset NREQ) is considered last and thus has lowest priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    win_idx = owner;
    cand    = owner;
    for (int k = NREQ; k >= 1; k--) begin
      cand = OW'((int'(owner) + k) % NREQ);
      if (req[cand]) win_idx = cand;
    end
  end

  assign dwell_done = (dwell == CW'(DWELL - 1));
  assign others_req = |(req & ~grant);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (|req) state_next = OWN;
      OWN: begin
        if (!req[owner])                   state_next = SWITCH;
        else if (dwell_done && others_req) state_next = SWITCH;
      end
      SWITCH:  state_next = (|req) ? OWN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      owner <= OW'(NREQ - 1);
      grant <= '0;
      dwell <= '0;
    end else begin
      state <= state_next;
      if (state != OWN && state_next == OWN) begin
        owner          <= win_idx;
        grant          <= '0;
        grant[win_idx] <= 1'b1;
        dwell          <= '0;
      end else if (state_next == OWN) begin
        if (!dwell_done) dwell <= dwell + CW'(1);
      end else begin
        grant <= '0;
        dwell <= '0;
      end
    end
  end

`ifdef SCREEN_ARB_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  // Free-running across all states so the blink cadence is independent of ownership.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end
`endif

  always_comb begin
    busy    = (state == OWN);
    display = '0;
    dots    = '0;
    en      = '0;
    if (state == OWN) begin
      display = src_display[owner];
      dots    = src_dots[owner];
`ifdef SCREEN_ARB_BLINK_EN
      en      = src_en[owner] & (blink_on ? 8'hFF : ~src_blink[owner]);
`else
      en      = src_en[owner];
`endif
    end
  end

endmodule
